// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: source count, vector width,
// FSM state encodings (also decoded by the control unit) and the priority encoder.
package int_ctrl_pkg;

  localparam int NSRC  = 4;
  localparam int VEC_W = 2;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'b00,
    IC_REQ     = 2'b01,
    IC_SERVICE = 2'b10
  } ic_state_e;

  // Lowest set index wins; bit 0 is the highest priority source.
  function automatic logic [VEC_W-1:0] prio_enc(input logic [NSRC-1:0] req);
    prio_enc = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) prio_enc = VEC_W'(i);
    end
  endfunction

endpackage

// File: rtl/int_ctrl_irq_sync_edge.sv
// One interrupt source: SYNC_STAGES-deep synchronizer, one-clock delay of the
// synchronized line, and the pending-set pulse (rising edge or level).
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic set
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   delay_q, delay_d;
  logic                   sync_s;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], irq};
    delay_d = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
      delay_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      delay_q <= delay_d;
    end
  end

  assign sync_s = chain_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign set = sync_s & ~delay_q;
    end else begin : g_level
      assign set = sync_s;
    end
  endgenerate

endmodule

// File: rtl/int_ctrl.sv
// Four-source prioritized interrupt controller with mask, global enable and a
// request/acknowledge/return handshake; vec_sel selects the vector register.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_in,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_d,
  input  logic             ei,
  input  logic             di,
  input  logic             int_ack,
  input  logic             reti,
  output logic             int_req,
  output logic [VEC_W-1:0] vec_sel,
  output logic             in_service,
  output logic [NSRC-1:0]  pending_o
);

  logic [NSRC-1:0]  set_vec;
  logic [NSRC-1:0]  clr;
  logic [NSRC-1:0]  elig;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  src_en_q, src_en_d;
  logic             gie_q, gie_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  ic_state_e        state_q, state_d;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .irq  (irq_in[g]),
      .set  (set_vec[g])
    );
  end

  always_comb begin
    gie_d = gie_q;
    if (ei) gie_d = 1'b1;
    if (di) gie_d = 1'b0;

    src_en_d = mask_we ? mask_d : src_en_q;
    elig     = pending_q & src_en_q;

    state_d = state_q;
    vec_d   = vec_q;
    clr     = '0;

    // A di strobe withdraws an outstanding request on the same edge, unless acked.
    case (state_q)
      IC_IDLE: begin
        if (gie_q && (elig != '0)) begin
          state_d = IC_REQ;
          vec_d   = prio_enc(elig);
        end
      end
      IC_REQ: begin
        if (int_ack) begin
          clr[vec_q] = 1'b1;
          state_d    = IC_SERVICE;
        end else if (!gie_d) begin
          state_d = IC_IDLE;
        end
      end
      IC_SERVICE: begin
        if (reti) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase

    pending_d = (pending_q & ~clr) | set_vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      src_en_q  <= '0;
      gie_q     <= 1'b0;
      vec_q     <= '0;
      state_q   <= IC_IDLE;
    end else begin
      pending_q <= pending_d;
      src_en_q  <= src_en_d;
      gie_q     <= gie_d;
      vec_q     <= vec_d;
      state_q   <= state_d;
    end
  end

  assign int_req    = (state_q == IC_REQ);
  assign in_service = (state_q == IC_SERVICE);
  assign vec_sel    = vec_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench: an edge-mode and a level-mode int_ctrl share stimulus and
// are compared every cycle against a behavioural model, plus directed scenario checks.
module tb_int_ctrl;

  localparam int SYNC = 2;
  localparam int EM[2] = '{1, 0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_d = '0;
  logic       ei = 1'b0, di = 1'b0, int_ack = 1'b0, reti = 1'b0;

  logic       int_req_e, in_service_e, int_req_l, in_service_l;
  logic [1:0] vec_sel_e, vec_sel_l;
  logic [3:0] pending_e, pending_l;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 = idle, 1 = requesting, 2 = in handler.
  int         m_mode[2];
  int         m_vec[2];
  logic [3:0] m_pend[2];
  logic [3:0] m_mask;
  logic       m_gie;
  logic [3:0] hist[$];

  always #5 clk = ~clk;

  int_ctrl #(.SYNC_STAGES(SYNC), .EDGE_MODE(1)) u_dut_edge (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_d(mask_d),
    .ei(ei), .di(di), .int_ack(int_ack), .reti(reti),
    .int_req(int_req_e), .vec_sel(vec_sel_e), .in_service(in_service_e), .pending_o(pending_e)
  );

  int_ctrl #(.SYNC_STAGES(SYNC), .EDGE_MODE(0)) u_dut_level (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_we(mask_we), .mask_d(mask_d),
    .ei(ei), .di(di), .int_ack(int_ack), .reti(reti),
    .int_req(int_req_l), .vec_sel(vec_sel_l), .in_service(in_service_l), .pending_o(pending_l)
  );

  function automatic int lowestSet(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0;
      m_vec[k]  = 0;
      m_pend[k] = '0;
    end
    m_mask = '0;
    m_gie  = 1'b0;
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(4'b0000);
  endtask

  // hist[0] is the irq_in sample taken at the most recent edge.
  task automatic modelStep();
    logic [3:0] s, sd, setv, elig, clrv;
    logic       gie_n;
    s     = hist[SYNC-1];
    sd    = hist[SYNC];
    gie_n = di ? 1'b0 : (ei ? 1'b1 : m_gie);
    for (int k = 0; k < 2; k++) begin
      setv = (EM[k] != 0) ? (s & ~sd) : s;
      clrv = '0;
      elig = m_pend[k] & m_mask;
      if (m_mode[k] == 0) begin
        if (m_gie && elig != 0) begin
          m_mode[k] = 1;
          m_vec[k]  = lowestSet(elig);
        end
      end else if (m_mode[k] == 1) begin
        if (int_ack) begin
          clrv      = 4'b0001 << m_vec[k];
          m_mode[k] = 2;
        end else if (!gie_n) begin
          m_mode[k] = 0;
        end
      end else begin
        if (reti) m_mode[k] = 0;
      end
      m_pend[k] = (m_pend[k] & ~clrv) | setv;
    end
    if (mask_we) m_mask = mask_d;
    m_gie = gie_n;
    hist.push_front(irq_in);
    void'(hist.pop_back());
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("req_edge",  4'(int_req_e),    4'(m_mode[0] == 1));
    chk("svc_edge",  4'(in_service_e), 4'(m_mode[0] == 2));
    chk("vec_edge",  4'(vec_sel_e),    4'(m_vec[0]));
    chk("pend_edge", pending_e,        m_pend[0]);
    chk("req_lvl",   4'(int_req_l),    4'(m_mode[1] == 1));
    chk("svc_lvl",   4'(in_service_l), 4'(m_mode[1] == 2));
    chk("vec_lvl",   4'(vec_sel_l),    4'(m_vec[1]));
    chk("pend_lvl",  pending_l,        m_pend[1]);
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_req"},  4'(int_req_e | int_req_l), 4'b0);
    chk({tag, "_svc"},  4'(in_service_e | in_service_l), 4'b0);
    chk({tag, "_vec"},  4'(vec_sel_e | vec_sel_l), 4'b0);
    chk({tag, "_pend"}, pending_e | pending_l, 4'b0);
  endtask

  task automatic applyStimulus(input logic [3:0] irq, input logic we, input logic [3:0] md,
                               input logic e, input logic d, input logic ack, input logic rt);
    irq_in = irq; mask_we = we; mask_d = md; ei = e; di = d; int_ack = ack; reti = rt;
    @(posedge clk);
    if (reset) modelReset();
    else modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and expects every output to drop at once.
  task automatic asyncReset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAllZero(tag);
    applyStimulus(irq_in, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    #2;
    irq_in = 4'b1111;
    #1;
    checkAllZero("rst_t0");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkAllZero("rst_hold");
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_pend", pending_e, 4'b1111);
    chk("t1_noreq", 4'(int_req_e), 4'b0);
    irq_in = 4'b0;
    asyncReset("t1_clear");

    // Single source with latency checks.
    applyStimulus(4'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t2_early", 4'(int_req_e), 4'b0);
    idle(1);
    chk("t2_req", 4'(int_req_e), 4'b1);
    chk("t2_vec", 4'(vec_sel_e), 4'd2);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_svc", 4'(in_service_e), 4'b1);
    chk("t2_pend", pending_e, 4'b0);
    idle(1);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_ret_req", 4'(int_req_e), 4'b0);
    chk("t2_ret_svc", 4'(in_service_e), 4'b0);

    // Priority and back-to-back service.
    applyStimulus(4'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t3_vec1", 4'(vec_sel_e), 4'd1);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_gap", 4'(int_req_e), 4'b0);
    idle(1);
    chk("t3_req3", 4'(int_req_e), 4'b1);
    chk("t3_vec3", 4'(vec_sel_e), 4'd3);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Masked source, then unmasked.
    applyStimulus(4'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("t4_pend", pending_e, 4'b0001);
    chk("t4_noreq", 4'(int_req_e), 4'b0);
    applyStimulus(4'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_wait", 4'(int_req_e), 4'b0);
    idle(1);
    chk("t4_req", 4'(int_req_e), 4'b1);
    chk("t4_vec", 4'(vec_sel_e), 4'd0);

    // New src0 event lands on the same edge as its acknowledge.
    applyStimulus(4'b0001, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_svc", 4'(in_service_e), 4'b1);
    chk("t5_pend", pending_e, 4'b0001);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t5_rereq", 4'(int_req_e), 4'b1);
    chk("t5_vec", 4'(vec_sel_e), 4'd0);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Withdrawal by di and re-request by ei, then reset mid-service.
    applyStimulus(4'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("t6_req", 4'(int_req_e), 4'b1);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_wd", 4'(int_req_e), 4'b0);
    chk("t6_kept", pending_e, 4'b0100);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_wait", 4'(int_req_e), 4'b0);
    idle(1);
    chk("t6_back", 4'(int_req_e), 4'b1);
    chk("t6_vec", 4'(vec_sel_e), 4'd2);
    applyStimulus(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    asyncReset("t6_midsvc");

    // Randomized traffic against the model.
    applyStimulus(4'b0, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (i == 200) asyncReset("rnd_rst");
      else if (i == 201) applyStimulus(4'b0, 1'b1, 4'(($urandom_range(1, 15))), 1'b1, 1'b0, 1'b0, 1'b0);
      else applyStimulus(($urandom % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'b0,
                         ($urandom % 16 == 0), 4'($urandom_range(0, 15)),
                         ($urandom % 8 == 0), ($urandom % 25 == 0),
                         ($urandom % 3 == 0), ($urandom % 4 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
